conv3x3_mac: RTL and testbench

- Downstream consumer of the 3x3 kernel coefficient ROM (`Filter`).
- Accepts one 3x3 window of 8-bit unsigned pixels per handshake.
- Walks the coefficient ROM over addresses 0..8 and multiply-accumulates coefficient × pixel.
- Emits one signed convolution result per window over a valid/ready output; it is the datapath core of the image-filtering pipeline.

---
 rtl/conv3x3_mac.sv | 132 +++++++++++++
 tb/tb_conv3x3_mac.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_mac.sv
// 3x3 convolution multiply-accumulate: walks a synchronous coefficient ROM over
// addresses 0..8 and emits one signed (optionally clamped) sum per pixel window.
`timescale 1ns/1ps
module conv3x3_mac #(
  parameter int unsigned ACC_W = 21,
  parameter bit          CLAMP = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [71:0]      in_window,
  output logic             coef_en,
  output logic [3:0]       coef_addr,
  input  logic [8:0]       coef_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data
);

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned WIN_W  = 72;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned COEF_W = 9;
  localparam int unsigned PROD_W = 18;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(8);

  typedef enum logic [1:0] {IDLE, FETCH, LAST, DONE} state_t;

  state_t                   state, state_nx;
  logic [WIN_W-1:0]         win, win_nx;
  logic signed [ACC_W-1:0]  acc, acc_nx;
  logic [ADDR_W-1:0]        addr_nx;
  logic                     en_nx, ready_nx, valid_nx;
  logic [ACC_W-1:0]         data_nx;
  logic [ADDR_W-1:0]        idx_d;
  logic                     mac_v;

  logic [PIX_W-1:0]         pixel;
  logic signed [COEF_W-1:0] coef_s, pix_s;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  sum;
  logic [ACC_W-1:0]         result;

  // Pixel index trails the address by one cycle to line up with ROM read latency.
  assign pixel  = win[{idx_d, 3'b000} +: PIX_W];
  assign coef_s = mac_v ? coef_data : '0;
  assign pix_s  = {1'b0, pixel};
  assign prod   = coef_s * pix_s;
  assign sum    = acc + ACC_W'(prod);

  always_comb begin
    result = sum;
    if (CLAMP) begin
      if (sum[ACC_W-1])
        result = '0;
      else if (sum > ACC_W'(255))
        result = ACC_W'(255);
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_nx = state;
    win_nx   = win;
    acc_nx   = acc;
    addr_nx  = coef_addr;
    en_nx    = coef_en;
    valid_nx = out_valid;
    data_nx  = out_data;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          state_nx = FETCH;
          win_nx   = in_window;
          acc_nx   = '0;
          en_nx    = 1'b1;
          addr_nx  = '0;
        end
      end
      FETCH: begin
        acc_nx = sum;
        if (coef_addr == LAST_ADDR) begin
          en_nx    = 1'b0;
          state_nx = LAST;
        end else begin
          addr_nx = coef_addr + ADDR_W'(1);
        end
      end
      LAST: begin
        data_nx  = result;
        valid_nx = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        if (out_ready) begin
          valid_nx = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    ready_nx = (state_nx == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      win       <= '0;
      acc       <= '0;
      coef_addr <= '0;
      coef_en   <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      idx_d     <= '0;
      mac_v     <= 1'b0;
    end else begin
      state     <= state_nx;
      win       <= win_nx;
      acc       <= acc_nx;
      coef_addr <= addr_nx;
      coef_en   <= en_nx;
      in_ready  <= ready_nx;
      out_valid <= valid_nx;
      out_data  <= data_nx;
      idx_d     <= coef_addr;
      mac_v     <= coef_en;
    end
  end

endmodule

// File: tb/tb_conv3x3_mac.sv
// Bench for conv3x3_mac: raw and clamped instances side by side, each fed by its
// own synchronous coefficient ROM, checked against a sum-of-products model.
`timescale 1ns/1ps
module tb_conv3x3_mac;

  localparam int ACC_W = 21;

  logic              clk, reset, in_valid, out_ready;
  logic [71:0]       in_window;
  logic              in_ready0, coef_en0, out_valid0;
  logic [3:0]        coef_addr0;
  logic [8:0]        coef_data0;
  logic [ACC_W-1:0]  out_data0;
  logic              in_ready1, coef_en1, out_valid1;
  logic [3:0]        coef_addr1;
  logic [8:0]        coef_data1;
  logic [ACC_W-1:0]  out_data1;

  logic signed [8:0] rom [9];

  int checks   = 0;
  int failures = 0;

  conv3x3_mac #(.ACC_W(ACC_W), .CLAMP(1'b0)) dut_raw (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_window(in_window), .coef_en(coef_en0), .coef_addr(coef_addr0),
    .coef_data(coef_data0), .out_valid(out_valid0), .out_ready(out_ready),
    .out_data(out_data0));

  conv3x3_mac #(.ACC_W(ACC_W), .CLAMP(1'b1)) dut_clamp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_window(in_window), .coef_en(coef_en1), .coef_addr(coef_addr1),
    .coef_data(coef_data1), .out_valid(out_valid1), .out_ready(out_ready),
    .out_data(out_data1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM models: synchronous read on enable, synchronous reset.
  always @(posedge clk) begin
    if (reset) coef_data0 <= '0;
    else if (coef_en0 && coef_addr0 < 4'd9) coef_data0 <= rom[coef_addr0];
  end
  always @(posedge clk) begin
    if (reset) coef_data1 <= '0;
    else if (coef_en1 && coef_addr1 < 4'd9) coef_data1 <= rom[coef_addr1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int conv_ref(input logic [71:0] w);
    int s = 0;
    for (int k = 0; k < 9; k++) s += int'(rom[k]) * int'(w[8*k +: 8]);
    return s;
  endfunction

  function automatic int clamp_ref(input int s);
    return (s < 0) ? 0 : (s > 255) ? 255 : s;
  endfunction

  task automatic set_laplacian();
    int lap [9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
    for (int k = 0; k < 9; k++) rom[k] = 9'(lap[k]);
  endtask

  task automatic set_random_rom();
    for (int k = 0; k < 9; k++) rom[k] = 9'($urandom_range(0, 511));
  endtask

  function automatic logic [71:0] rand_win();
    logic [95:0] r = {$urandom, $urandom, $urandom};
    return r[71:0];
  endfunction

  // One window through both instances with out_ready high.
  task automatic run_window(input string tag, input logic [71:0] w,
                            input int exp_raw, input int exp_cl);
    int n, lat;
    bit seq_ok;
    @(negedge clk);
    in_window = w;
    in_valid  = 1'b1;
    n = 0;
    while (in_ready0 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    check({tag, " accept"}, 32'(in_ready0), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    seq_ok = (coef_en0 === 1'b1) && (coef_addr0 === 4'd0);
    lat = 0;
    while (out_valid0 !== 1'b1 && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (lat <= 8 && (coef_addr0 !== 4'(lat) || coef_en0 !== 1'b1)) seq_ok = 1'b0;
      if (lat == 9 && coef_en0 !== 1'b0) seq_ok = 1'b0;
    end
    check({tag, " addr_seq"}, 32'(seq_ok), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'd10);
    check({tag, " raw"}, 32'($signed(out_data0)), 32'(exp_raw));
    check({tag, " clamp"}, 32'($signed(out_data1)), 32'(exp_cl));
    check({tag, " clamp_valid"}, 32'(out_valid1), 32'd1);
    @(posedge clk); #1;
    check({tag, " pulse"}, 32'(out_valid0), 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [71:0] w;
    int          exp_raw;
    int          exp_cl;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [6];
    logic [71:0] wa, wb, tw [3];
    logic [ACC_W-1:0] held;
    int n, lat, nout, last_t, te [3];
    bit ok;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_window = '0;
    set_laplacian();
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(in_ready0), 32'd1);
    check("reset out_valid", 32'(out_valid0), 32'd0);
    check("reset out_data", 32'(out_data0), 32'd0);
    check("reset coef", 32'({coef_en0, coef_addr0}), 32'd0);
    @(negedge clk); reset = 1'b0;

    // Directed Laplacian vectors
    vt[0] = '{"flat128", {9{8'd128}}, 0, 0};
    vt[1] = '{"centre255", 72'hFF << 32, 1020, 255};
    vt[2] = '{"cross255", (72'hFF << 8) | (72'hFF << 24) | (72'hFF << 40) | (72'hFF << 56), -1020, 0};
    vt[3] = '{"centre10", 72'd10 << 32, 40, 40};
    vt[4] = '{"c100_n50", (72'd100 << 32) | (72'd50 << 8), 350, 255};
    vt[5] = '{"c30_cross1", (72'd30 << 32) | (72'd1 << 8) | (72'd1 << 24) | (72'd1 << 40) | (72'd1 << 56), 116, 116};
    for (int i = 0; i < 6; i++) run_window(vt[i].name, vt[i].w, vt[i].exp_raw, vt[i].exp_cl);

    // Random coefficients and pixels against the model
    for (int i = 0; i < 6; i++) begin
      set_random_rom();
      wa = rand_win();
      run_window("random", wa, conv_ref(wa), clamp_ref(conv_ref(wa)));
    end
    for (int k = 0; k < 9; k++) rom[k] = -9'sd256;
    run_window("min_extreme", {9{8'hFF}}, conv_ref({9{8'hFF}}), 0);
    for (int k = 0; k < 9; k++) rom[k] = 9'sd255;
    run_window("max_extreme", {9{8'hFF}}, conv_ref({9{8'hFF}}), 255);

    // Backpressure: result holds, second window waits for the output handshake
    set_laplacian();
    wa = 72'hFF << 32;
    wb = 72'd10 << 32;
    @(negedge clk);
    in_window = wa; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    while (in_ready0 !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    in_window = wb;
    ok = 1'b1; lat = 0;
    while (out_valid0 !== 1'b1 && lat < 30) begin
      if (in_ready0 !== 1'b0) ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    check("bp latency", 32'(lat), 32'd10);
    check("bp data", 32'($signed(out_data0)), 32'd1020);
    held = out_data0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (out_data0 !== held || out_valid0 !== 1'b1 || in_ready0 !== 1'b0) ok = 1'b0;
    end
    check("bp hold", 32'(ok), 32'd1);
    check("bp clamp data", 32'(out_data1), 32'd255);
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp release", 32'({out_valid0, in_ready0}), 32'b01);
    @(posedge clk); #1;
    check("bp second accept", 32'({in_ready0, coef_en0}), 32'b01);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid0 !== 1'b1 && lat < 30) begin @(posedge clk); #1; lat++; end
    check("bp second latency", 32'(lat), 32'd10);
    check("bp second data", 32'($signed(out_data0)), 32'd40);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of FETCH
    run_window("pre_reset", 72'd7 << 32, 28, 28);
    @(negedge clk);
    in_window = 72'hFF << 32; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (coef_addr0 !== 4'd4 && n < 20) begin @(posedge clk); #1; n++; end
    check("reach addr4", 32'(coef_addr0), 32'd4);
    #2 reset = 1'b1;
    #1;
    check("async in_ready", 32'({in_ready0, in_ready1}), 32'b11);
    check("async out_valid", 32'(out_valid0), 32'd0);
    check("async out_data", 32'(out_data0), 32'd0);
    check("async coef", 32'({coef_en0, coef_addr0}), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ok = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) ok = 1'b0;
    end
    check("no partial output", 32'(ok), 32'd1);
    run_window("post_reset", 72'd10 << 32, 40, 40);

    // Back-to-back throughput with in_window churn during FETCH
    set_random_rom();
    for (int j = 0; j < 3; j++) begin
      tw[j] = rand_win();
      te[j] = conv_ref(tw[j]);
    end
    @(negedge clk);
    in_window = tw[0]; in_valid = 1'b1; out_ready = 1'b1;
    check("tp idle", 32'(in_ready0), 32'd1);
    nout = 0; last_t = 0;
    for (int cyc = 0; cyc < 38; cyc++) begin
      @(posedge clk); #1;
      if (out_valid0 === 1'b1 && nout < 3) begin
        check("tp raw", 32'($signed(out_data0)), 32'(te[nout]));
        check("tp clamp", 32'(out_data1), 32'(clamp_ref(te[nout])));
        check("tp spacing", 32'(cyc - last_t), (nout == 0) ? 32'd10 : 32'd12);
        last_t = cyc;
        nout++;
      end
      if (cyc % 12 == 3) in_window = rand_win();
      if (cyc % 12 == 11 && cyc / 12 + 1 < 3) in_window = tw[cyc / 12 + 1];
      if (cyc == 24) in_valid = 1'b0;
    end
    check("tp count", 32'(nout), 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
